// File: rtl/matrix_stream_sequencer_if.sv
// Stream bundle carrying H rows and alpha columns from the sequencer
// to the downstream consumer. Both channels use valid/ready/last.
interface matrix_stream_sequencer_if #(
  parameter int J  = 14,
  parameter int DW = 64
);
  logic [J-1:0]    H_row;
  logic            H_row_tvalid;
  logic            H_row_tready;
  logic            H_row_tlast;
  logic [J*DW-1:0] alpha_u_col;
  logic            alpha_u_col_tvalid;
  logic            alpha_u_col_tready;
  logic            alpha_u_col_tlast;

  modport master (
    output H_row, H_row_tvalid, H_row_tlast,
    output alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast,
    input  H_row_tready, alpha_u_col_tready
  );

  modport slave (
    input  H_row, H_row_tvalid, H_row_tlast,
    input  alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast,
    output H_row_tready, alpha_u_col_tready
  );
endinterface

// File: rtl/matrix_stream_sequencer.sv
// Run-time loadable H / alpha stream sequencer. Stores an H matrix and a
// set of alpha columns, then replays them frame by frame: all H rows of a
// frame, then all alpha columns, with full tready backpressure.
module matrix_stream_sequencer #(
  parameter int J      = 14,
  parameter int N_ROWS = 7,
  parameter int N_COLS = 2,
  parameter int DW     = 64,
  parameter int FW     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      h_wr_en,
  input  logic [$clog2(N_ROWS):0]   h_wr_addr,
  input  logic [J-1:0]              h_wr_data,
  input  logic                      a_wr_en,
  input  logic [$clog2(N_COLS):0]   a_wr_addr,
  input  logic [J*DW-1:0]           a_wr_data,
  input  logic                      start,
  input  logic                      abort,
  input  logic [FW-1:0]             frames,
  output logic                      busy,
  output logic                      done,
  matrix_stream_sequencer_if.master m
);
  localparam int HAW = $clog2(N_ROWS) + 1;
  localparam int AAW = $clog2(N_COLS) + 1;
  localparam int RW  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CW  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam logic [HAW-1:0] H_LIMIT  = HAW'(N_ROWS);
  localparam logic [AAW-1:0] A_LIMIT  = AAW'(N_COLS);
  localparam logic [RW-1:0]  ROW_LAST = RW'(N_ROWS - 1);
  localparam logic [CW-1:0]  COL_LAST = CW'(N_COLS - 1);
  localparam logic [FW:0]    FRAME_ONE = 1;

  typedef enum logic [1:0] {IDLE, H_SEND, A_SEND, DONE} state_t;

  logic [J-1:0]    h_mem [N_ROWS];
  logic [J*DW-1:0] a_mem [N_COLS];

  state_t          state_reg, state_next;
  logic [RW-1:0]   row_cnt_reg, row_cnt_next, row_inc;
  logic [CW-1:0]   col_cnt_reg, col_cnt_next, col_inc;
  logic [FW-1:0]   frame_cnt_reg, frame_cnt_next;
  logic [FW-1:0]   frames_lat_reg, frames_lat_next;
  logic [FW:0]     frame_inc;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            h_valid_reg, h_valid_next, h_last_reg, h_last_next;
  logic [J-1:0]    h_data_reg, h_data_next;
  logic            a_valid_reg, a_valid_next, a_last_reg, a_last_next;
  logic [J*DW-1:0] a_data_reg, a_data_next;

  // Store writes: only while no run is active and only for in-range addresses.
  always_ff @(posedge clk) begin
    if (rst_n && !busy_reg) begin
      if (h_wr_en && (h_wr_addr < H_LIMIT)) h_mem[h_wr_addr[RW-1:0]] <= h_wr_data;
      if (a_wr_en && (a_wr_addr < A_LIMIT)) a_mem[a_wr_addr[CW-1:0]] <= a_wr_data;
    end
  end

  // State, counters and registered stream outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      row_cnt_reg    <= '0;
      col_cnt_reg    <= '0;
      frame_cnt_reg  <= '0;
      frames_lat_reg <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      h_valid_reg    <= 1'b0;
      h_last_reg     <= 1'b0;
      h_data_reg     <= '0;
      a_valid_reg    <= 1'b0;
      a_last_reg     <= 1'b0;
      a_data_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      row_cnt_reg    <= row_cnt_next;
      col_cnt_reg    <= col_cnt_next;
      frame_cnt_reg  <= frame_cnt_next;
      frames_lat_reg <= frames_lat_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      h_valid_reg    <= h_valid_next;
      h_last_reg     <= h_last_next;
      h_data_reg     <= h_data_next;
      a_valid_reg    <= a_valid_next;
      a_last_reg     <= a_last_next;
      a_data_reg     <= a_data_next;
    end
  end

  // Next-state logic; the following beat is preloaded on acceptance so
  // there is no bubble between consecutive beats or between channels.
  always_comb begin
    state_next      = state_reg;
    row_cnt_next    = row_cnt_reg;
    col_cnt_next    = col_cnt_reg;
    frame_cnt_next  = frame_cnt_reg;
    frames_lat_next = frames_lat_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;
    h_valid_next    = h_valid_reg;
    h_last_next     = h_last_reg;
    h_data_next     = h_data_reg;
    a_valid_next    = a_valid_reg;
    a_last_next     = a_last_reg;
    a_data_next     = a_data_reg;
    row_inc         = row_cnt_reg + RW'(1);
    col_inc         = col_cnt_reg + CW'(1);
    frame_inc       = {1'b0, frame_cnt_reg} + FRAME_ONE;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          frames_lat_next = (frames == '0) ? FW'(1) : frames;
          frame_cnt_next  = '0;
          row_cnt_next    = '0;
          busy_next       = 1'b1;
          h_valid_next    = 1'b1;
          h_data_next     = h_mem[0];
          h_last_next     = (ROW_LAST == '0);
          state_next      = H_SEND;
        end
      end
      H_SEND: begin
        if (h_valid_reg && m.H_row_tready) begin
          if (row_cnt_reg == ROW_LAST) begin
            h_valid_next = 1'b0;
            h_last_next  = 1'b0;
            col_cnt_next = '0;
            a_valid_next = 1'b1;
            a_data_next  = a_mem[0];
            a_last_next  = (COL_LAST == '0);
            state_next   = A_SEND;
          end else begin
            row_cnt_next = row_inc;
            h_data_next  = h_mem[row_inc];
            h_last_next  = (row_inc == ROW_LAST);
          end
        end
      end
      A_SEND: begin
        if (a_valid_reg && m.alpha_u_col_tready) begin
          if (col_cnt_reg == COL_LAST) begin
            a_valid_next   = 1'b0;
            a_last_next    = 1'b0;
            frame_cnt_next = frame_inc[FW-1:0];
            if (frame_inc < {1'b0, frames_lat_reg}) begin
              row_cnt_next = '0;
              h_valid_next = 1'b1;
              h_data_next  = h_mem[0];
              h_last_next  = (ROW_LAST == '0);
              state_next   = H_SEND;
            end else begin
              busy_next  = 1'b0;
              done_next  = 1'b1;
              state_next = DONE;
            end
          end else begin
            col_cnt_next = col_inc;
            a_data_next  = a_mem[col_inc];
            a_last_next  = (col_inc == COL_LAST);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort drops any in-flight beat, even one being accepted this cycle.
    if (abort && (state_reg != IDLE)) begin
      state_next   = IDLE;
      busy_next    = 1'b0;
      done_next    = 1'b0;
      h_valid_next = 1'b0;
      h_last_next  = 1'b0;
      h_data_next  = '0;
      a_valid_next = 1'b0;
      a_last_next  = 1'b0;
      a_data_next  = '0;
    end
  end

  assign busy                 = busy_reg;
  assign done                 = done_reg;
  assign m.H_row              = h_data_reg;
  assign m.H_row_tvalid       = h_valid_reg;
  assign m.H_row_tlast        = h_last_reg;
  assign m.alpha_u_col        = a_data_reg;
  assign m.alpha_u_col_tvalid = a_valid_reg;
  assign m.alpha_u_col_tlast  = a_last_reg;
endmodule

// File: tb/tb_matrix_stream_sequencer.sv
// Scoreboard bench for matrix_stream_sequencer: stimulus pushes expected
// beats into a queue, a negedge monitor pops and compares accepted beats.
module tb_matrix_stream_sequencer;
  localparam int J = 14, N_ROWS = 7, N_COLS = 2, DW = 64, FW = 8;
  localparam int CWD = J * DW;
  localparam int K_H = 0, K_A = 1, K_DONE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic h_wr_en = 1'b0, a_wr_en = 1'b0;
  logic [3:0] h_wr_addr = '0;
  logic [1:0] a_wr_addr = '0;
  logic [J-1:0] h_wr_data = '0;
  logic [CWD-1:0] a_wr_data = '0;
  logic start = 1'b0, abort = 1'b0;
  logic [FW-1:0] frames = '0;
  logic busy, done;

  always #5 clk = ~clk;

  matrix_stream_sequencer_if #(.J(J), .DW(DW)) s_if ();

  matrix_stream_sequencer #(.J(J), .N_ROWS(N_ROWS), .N_COLS(N_COLS), .DW(DW), .FW(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_wr_en(h_wr_en), .h_wr_addr(h_wr_addr), .h_wr_data(h_wr_data),
    .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
    .start(start), .abort(abort), .frames(frames),
    .busy(busy), .done(done), .m(s_if)
  );

  typedef struct {
    int             kind;
    logic [CWD-1:0] data;
    logic           last;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  logic [J-1:0]   h_tab [N_ROWS];
  logic [CWD-1:0] a_tab [N_COLS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_col(input string name, input logic [CWD-1:0] act, input logic [CWD-1:0] req);
    checks++;
    if (act !== req) begin
      int bad = 0;
      failures++;
      for (int e = J - 1; e >= 0; e--)
        if (act[e*DW +: DW] !== req[e*DW +: DW]) bad = e;
      $display("FAIL %s elem=%0d actual=%h required=%h", name, bad,
               act[bad*DW +: DW], req[bad*DW +: DW]);
    end
  endtask

  task automatic pop_check(input string name, input int kind, input logic [CWD-1:0] data, input logic last);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected event kind=%0d (none required)", name, kind);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_kind"}, 64'(kind), 64'(e.kind));
      chk_col({name, "_data"}, data, e.data);
      chk({name, "_last"}, 64'(last), 64'(e.last));
    end
  endtask

  // Monitor: compares every accepted beat and done pulse against the queue.
  int   neg_cnt = 0, last_alpha_neg = -100;
  logic h_stall_prev = 1'b0, a_stall_prev = 1'b0, abort_prev = 1'b0;
  logic [J-1:0]   h_stall_data = '0;
  logic [CWD-1:0] a_stall_data = '0;
  always @(negedge clk) begin
    neg_cnt++;
    if (rst_n) begin
      if (s_if.H_row_tvalid || s_if.alpha_u_col_tvalid)
        chk("one_channel_valid", 64'(s_if.H_row_tvalid & s_if.alpha_u_col_tvalid), 64'd0);
      if (h_stall_prev && !abort_prev) begin
        chk("h_hold_valid", 64'(s_if.H_row_tvalid), 64'd1);
        chk("h_hold_data", 64'(s_if.H_row), 64'(h_stall_data));
      end
      if (a_stall_prev && !abort_prev) begin
        chk("a_hold_valid", 64'(s_if.alpha_u_col_tvalid), 64'd1);
        chk_col("a_hold_data", s_if.alpha_u_col, a_stall_data);
      end
      if (s_if.H_row_tvalid && s_if.H_row_tready && !abort) begin
        pop_check("h_beat", K_H, CWD'(s_if.H_row), s_if.H_row_tlast);
        $display("H beat row=%h last=%0b t=%0t", s_if.H_row, s_if.H_row_tlast, $time);
      end
      if (s_if.alpha_u_col_tvalid && s_if.alpha_u_col_tready && !abort) begin
        pop_check("a_beat", K_A, s_if.alpha_u_col, s_if.alpha_u_col_tlast);
        last_alpha_neg = neg_cnt;
        $display("A beat elem0=%h last=%0b t=%0t", s_if.alpha_u_col[DW-1:0], s_if.alpha_u_col_tlast, $time);
      end
      if (done) begin
        pop_check("done_evt", K_DONE, '0, 1'b0);
        chk("done_gap", 64'(neg_cnt - last_alpha_neg), 64'd1);
        $display("DONE pulse t=%0t", $time);
      end
    end
    h_stall_prev = rst_n && s_if.H_row_tvalid && !s_if.H_row_tready;
    a_stall_prev = rst_n && s_if.alpha_u_col_tvalid && !s_if.alpha_u_col_tready;
    h_stall_data = s_if.H_row;
    a_stall_data = s_if.alpha_u_col;
    abort_prev   = abort;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_h(input int r);
    exp_t e;
    e.kind = K_H; e.data = CWD'(h_tab[r]); e.last = (r == N_ROWS - 1);
    exp_q.push_back(e);
  endtask

  task automatic push_run(input int nf);
    exp_t e;
    for (int f = 0; f < nf; f++) begin
      for (int r = 0; r < N_ROWS; r++) push_h(r);
      for (int c = 0; c < N_COLS; c++) begin
        e.kind = K_A; e.data = a_tab[c]; e.last = (c == N_COLS - 1);
        exp_q.push_back(e);
      end
    end
    e.kind = K_DONE; e.data = '0; e.last = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input int f);
    start = 1'b1;
    frames = FW'(f);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int req);
    int n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk(name, 64'(n), 64'(req));
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_h_valid"}, 64'(s_if.H_row_tvalid), 64'd0);
    chk({name, "_h_last"}, 64'(s_if.H_row_tlast), 64'd0);
    chk({name, "_h_row"}, 64'(s_if.H_row), 64'd0);
    chk({name, "_a_valid"}, 64'(s_if.alpha_u_col_tvalid), 64'd0);
    chk({name, "_a_last"}, 64'(s_if.alpha_u_col_tlast), 64'd0);
    chk_col({name, "_a_col"}, s_if.alpha_u_col, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    h_tab[0] = 14'h18A3; h_tab[1] = 14'h0D4A; h_tab[2] = 14'h14C5; h_tab[3] = 14'h230B;
    h_tab[4] = 14'h22B4; h_tab[5] = 14'h2538; h_tab[6] = 14'h1A54;
    for (int e = 0; e < J; e++) begin
      a_tab[0][e*DW +: DW] = 64'h3FF0000000000000 | (64'(e) << 32);
      a_tab[1][e*DW +: DW] = 64'hC000000000000000 | 64'(e * 3 + 1);
    end
    s_if.H_row_tready = 1'b1;
    s_if.alpha_u_col_tready = 1'b1;

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Load stores
    for (int r = 0; r < N_ROWS; r++) begin
      h_wr_en = 1'b1; h_wr_addr = 4'(r); h_wr_data = h_tab[r];
      tick();
    end
    h_wr_en = 1'b0;
    for (int c = 0; c < N_COLS; c++) begin
      a_wr_en = 1'b1; a_wr_addr = 2'(c); a_wr_data = a_tab[c];
      tick();
    end
    a_wr_en = 1'b0;

    // Single frame, full throughput: 7 H + 2 alpha beats, done 9 edges after start
    push_run(1);
    do_start(1);
    chk("t1_first_valid", 64'(s_if.H_row_tvalid), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done("t1_cycles", 9);
    chk("t1_busy_at_done", 64'(busy), 64'd0);
    tick();
    chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: beat 2 stalled for 3 cycles
    push_run(1);
    do_start(1);
    tick();
    s_if.H_row_tready = 1'b0;
    tick(); tick(); tick();
    s_if.H_row_tready = 1'b1;
    wait_done("t2_cycles", 8);
    tick();
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Three frames
    push_run(3);
    do_start(3);
    wait_done("t3_cycles", 27);
    tick();
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // Abort on H beat 4, then fresh restart
    for (int r = 0; r < 3; r++) push_h(r);
    do_start(1);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_h_valid", 64'(s_if.H_row_tvalid), 64'd0);
    chk("t4_h_last", 64'(s_if.H_row_tlast), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_done", 64'(done), 64'd0);
    chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);
    tick(); tick(); tick();
    push_run(1);
    do_start(1);
    wait_done("t4_restart_cycles", 9);
    tick();

    // start together with abort in IDLE: abort wins
    start = 1'b1; abort = 1'b1; frames = 8'd1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_h_valid", 64'(s_if.H_row_tvalid), 64'd0);
    tick();

    // frames=0 behaves as one frame
    push_run(1);
    do_start(0);
    wait_done("t6_cycles", 9);
    tick();

    // Writes while busy and out-of-range writes are dropped; start while busy ignored
    push_run(1);
    do_start(1);
    h_wr_en = 1'b1; h_wr_addr = 4'd2; h_wr_data = 14'h3FFF;
    start = 1'b1; frames = 8'd3;
    tick();
    h_wr_en = 1'b0; start = 1'b0;
    wait_done("t7_busy_run_cycles", 8);
    tick();
    h_wr_en = 1'b1; h_wr_addr = 4'd7; h_wr_data = 14'h3FFF;
    a_wr_en = 1'b1; a_wr_addr = 2'd2; a_wr_data = '1;
    tick();
    h_wr_en = 1'b0; a_wr_en = 1'b0;
    push_run(1);
    do_start(1);
    wait_done("t7_replay_cycles", 9);
    tick();

    // Reset during A_SEND, then replay from unchanged storage
    for (int r = 0; r < N_ROWS; r++) push_h(r);
    do_start(1);
    for (int i = 0; i < 7; i++) tick();
    chk("t8_in_alpha", 64'(s_if.alpha_u_col_tvalid), 64'd1);
    rst_n = 1'b0;
    tick();
    check_all_zero("t8_reset");
    chk("t8_queue_empty", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b1;
    tick();
    push_run(1);
    do_start(1);
    wait_done("t8_replay_cycles", 9);
    tick(); tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
